// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver; define UART_RX_PARITY_EN to add an even-parity bit and parity_err
module uart_rx #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic       uclk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);
    localparam int BPS_CNT = CLK_FREQ / BAUD;
    localparam int CW = $clog2(BPS_CNT);
    localparam logic [CW-1:0] HALF = CW'(BPS_CNT / 2);
    localparam logic [CW-1:0] LAST = CW'(BPS_CNT - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP
`ifdef UART_RX_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t        r_state, w_next;
    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_bidx;
    logic [7:0]    r_shift;
    logic          w_rxd_s, w_mid, w_wrap, w_done, w_ferr;
`ifdef UART_RX_PARITY_EN
    logic          r_par, w_perr, w_par_bad;
    assign w_par_bad = ^r_shift ^ r_par;
`endif

    assign w_rxd_s = r_sync[1];
    assign w_mid   = r_cnt == HALF;
    assign w_wrap  = r_cnt == LAST;

    // two-flop synchronizer; resets to the idle-high line level
    always_ff @(posedge uclk or negedge rst_n) begin
        if (!rst_n) r_sync <= 2'b11;
        else        r_sync <= {r_sync[0], rxd};
    end

    // state register
    always_ff @(posedge uclk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // next state and the stop-bit verdict, decided at the stop mid-bit sample
    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        w_ferr = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_perr = 1'b0;
`endif
        case (r_state)
            IDLE:  w_next = w_rxd_s ? IDLE : START;
            START: w_next = (w_mid && w_rxd_s) ? IDLE : (w_wrap ? DATA : START);
`ifdef UART_RX_PARITY_EN
            DATA:   w_next = (w_wrap && r_bidx == 4'd8) ? PARITY : DATA;
            PARITY: w_next = w_wrap ? STOP : PARITY;
`else
            DATA:   w_next = (w_wrap && r_bidx == 4'd8) ? STOP : DATA;
`endif
            STOP: if (w_mid) begin
                w_next = IDLE;
                w_ferr = !w_rxd_s;
`ifdef UART_RX_PARITY_EN
                w_done = w_rxd_s && !w_par_bad;
                w_perr = w_rxd_s && w_par_bad;
`else
                w_done = w_rxd_s;
`endif
            end
            default: w_next = IDLE;
        endcase
    end

    // baud counter, bit index, shift register and registered outputs
    always_ff @(posedge uclk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_bidx    <= '0;
            r_shift   <= '0;
            rx_data   <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par      <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            r_cnt  <= (r_state == IDLE || w_wrap) ? '0 : r_cnt + CW'(1);
            r_bidx <= (r_state == IDLE) ? '0 : r_bidx + {3'b000, w_wrap};
            if (r_state == DATA && w_mid) r_shift[3'(r_bidx - 4'd1)] <= w_rxd_s;
`ifdef UART_RX_PARITY_EN
            if (r_state == PARITY && w_mid) r_par <= w_rxd_s;
            parity_err <= w_perr;
`endif
            if (w_done) rx_data <= r_shift;
            rx_done   <= w_done;
            frame_err <= w_ferr;
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into uart_rx, scoreboard queue checked by a pulse monitor
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int  BPS  = 16;
    localparam int  HALF = 8;
    localparam real BIT  = 160.0;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif

    logic       uclk = 1'b0, rst_n = 1'b0, rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done, frame_err, w_perr;

    uart_rx #(.CLK_FREQ(1000000), .BAUD(62500)) dut (
        .uclk(uclk), .rst_n(rst_n), .rxd(rxd), .rx_data(rx_data),
        .rx_done(rx_done), .frame_err(frame_err)
`ifdef UART_RX_PARITY_EN
        , .parity_err(w_perr)
`endif
    );
`ifndef UART_RX_PARITY_EN
    assign w_perr = 1'b0;
`endif

    always #5 uclk = ~uclk;

    int cyc = 0;
    always @(posedge uclk) cyc <= cyc + 1;

    typedef struct { int kind; logic [7:0] data; int at; } ev_t;
    ev_t        q[$];
    int         n_cmp = 0, n_bad = 0;
    logic [7:0] last_good = 8'h00;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // kind 0 = rx_done, 1 = frame_err, 2 = parity_err; at = expected pulse cycle (0 = unchecked)
    task automatic send(input logic [7:0] d, input real bit_ns, input bit stop, input bit par, input bit timed);
        ev_t e;
        e.at = timed ? cyc + 4 + NB * BPS + HALF : 0;
        if (!stop) begin
            e.kind = 1; e.data = last_good;
`ifdef UART_RX_PARITY_EN
        end else if (par != ^d) begin
            e.kind = 2; e.data = last_good;
`endif
        end else begin
            e.kind = 0; e.data = d; last_good = d;
        end
        q.push_back(e);
        rxd = 1'b0; #(bit_ns);
        for (int i = 0; i < 8; i++) begin rxd = d[i]; #(bit_ns); end
`ifdef UART_RX_PARITY_EN
        rxd = par; #(bit_ns);
`endif
        rxd = stop; #(bit_ns);
        rxd = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && q.size() != 0; i++) @(posedge uclk);
        chk("drain", q.size(), 0);
        @(posedge uclk); #1;
    endtask

    always @(negedge uclk) begin : mon
        ev_t e;
        int  got;
        if (rst_n && (rx_done || frame_err || w_perr)) begin
            got = rx_done ? 0 : (frame_err ? 1 : 2);
            chk("exclusive", int'(rx_done) + int'(frame_err) + int'(w_perr), 1);
            if (q.size() == 0) chk("unexpected_pulse", got, -1);
            else begin
                e = q.pop_front();
                chk("kind", got, e.kind);
                chk("rx_data", int'(rx_data), int'(e.data));
                if (e.at != 0) chk("latency", cyc, e.at);
            end
        end
    end

    initial begin
        logic [7:0] c3;
        c3 = 8'hC3;
        repeat (3) @(posedge uclk); #1;
        chk("rst_rx_data", int'(rx_data), 0);
        chk("rst_rx_done", int'(rx_done), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        rst_n = 1'b1;
        repeat (4) @(posedge uclk); #1;
        for (int b = 1; b < 100; b++) send(8'(b), BIT, 1'b1, ^(8'(b)), 1'b1);
        send(8'hFF, BIT, 1'b1, 1'b0, 1'b1);
        send(8'h00, BIT, 1'b1, 1'b0, 1'b1);
        drain();
        rxd = 1'b0; #40; rxd = 1'b1; #480;
        send(8'hA5, BIT, 1'b1, 1'b0, 1'b1);
        drain();
        send(8'h3C, BIT, 1'b0, 1'b0, 1'b1);
        #320;
        send(8'h5A, BIT, 1'b1, 1'b0, 1'b1);
        drain();
        rxd = 1'b0; #(BIT);
        for (int i = 0; i < 4; i++) begin rxd = c3[i]; #(BIT); end
        rxd = c3[4]; #40;
        rst_n = 1'b0; #20;
        chk("midrst_rx_data", int'(rx_data), 0);
        chk("midrst_rx_done", int'(rx_done), 0);
        #20; rxd = 1'b1; #10; rst_n = 1'b1;
        last_good = 8'h00;
        #320;
        chk("postrst_rx_data", int'(rx_data), 0);
        send(8'h81, BIT, 1'b1, 1'b0, 1'b1);
        drain();
        send(8'h55, BIT / 1.03, 1'b1, 1'b0, 1'b0);
        @(posedge uclk); #321;
        send(8'h55, BIT / 0.97, 1'b1, 1'b0, 1'b0);
        drain();
`ifdef UART_RX_PARITY_EN
        send(8'h07, BIT, 1'b1, 1'b1, 1'b1);
        #320;
        send(8'h07, BIT, 1'b1, 1'b0, 1'b1);
        drain();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
